// File: rtl/ex_stage_if.sv
// Handshake bundle between operand-read, the execute stage and writeback.
// master drives instructions and the writeback ready; slave is the execute stage.
interface ex_stage_if #(
  parameter int XLEN = 32,
  parameter int XCNT = 32
);
  localparam int RW = $clog2(XCNT);

  logic            IN_VALID;
  logic            IN_READY;
  logic [XLEN-1:0] IN_PC;
  logic [3:0]      IN_ALU_OP;
  logic [XLEN-1:0] IN_OP1;
  logic [XLEN-1:0] IN_OP2;
  logic [XLEN-1:0] IN_IMM;
  logic [RW-1:0]   IN_RD;
  logic            IN_JAL;
  logic            IN_JALR;
  logic            IN_BRANCH;
  logic [2:0]      IN_BR_OP;
  logic            FLUSH;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] OUT_RESULT;
  logic [RW-1:0]   OUT_RD;
  logic            OUT_WE;
  logic            OUT_ILLEGAL;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            BUSY;

  modport master (
    output IN_VALID, IN_PC, IN_ALU_OP, IN_OP1, IN_OP2, IN_IMM, IN_RD,
           IN_JAL, IN_JALR, IN_BRANCH, IN_BR_OP, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_WE, OUT_ILLEGAL,
           REDIRECT, REDIRECT_PC, BUSY
  );

  modport slave (
    input  IN_VALID, IN_PC, IN_ALU_OP, IN_OP1, IN_OP2, IN_IMM, IN_RD,
           IN_JAL, IN_JALR, IN_BRANCH, IN_BR_OP, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_WE, OUT_ILLEGAL,
           REDIRECT, REDIRECT_PC, BUSY
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I-class execute stage: ALU, branch/jump resolution, one registered result slot.
// Define EX_MUL_EN to add the iterative shift-add multiplier (op 10); otherwise op 10 is illegal.
module ex_stage #(
  parameter int XLEN = 32,
  parameter int XCNT = 32
) (
  input  logic CLK,
  input  logic RSTN,
  ex_stage_if.slave bus
);
  localparam int RW  = $clog2(XCNT);
  localparam int SHW = $clog2(XLEN);

  logic            out_valid_reg;
  logic [XLEN-1:0] result_reg;
  logic [RW-1:0]   rd_reg;
  logic            we_reg;
  logic            illegal_reg;
  logic            redirect_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic            busy;

  logic            accept;
  logic            in_ready;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_result;
  logic            alu_legal;
  logic            is_mul;
  logic            br_taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jump_target;
  logic            rd_nz;

  always_comb begin
    shamt      = bus.IN_OP2[SHW-1:0];
    alu_result = '0;
    alu_legal  = 1'b1;
    is_mul     = 1'b0;
    case (bus.IN_ALU_OP)
      4'd0: alu_result = bus.IN_OP1 + bus.IN_OP2;
      4'd1: alu_result = bus.IN_OP1 - bus.IN_OP2;
      4'd2: alu_result = bus.IN_OP1 << shamt;
      4'd3: alu_result = {{(XLEN-1){1'b0}}, $signed(bus.IN_OP1) < $signed(bus.IN_OP2)};
      4'd4: alu_result = {{(XLEN-1){1'b0}}, bus.IN_OP1 < bus.IN_OP2};
      4'd5: alu_result = bus.IN_OP1 ^ bus.IN_OP2;
      4'd6: alu_result = bus.IN_OP1 >> shamt;
      4'd7: alu_result = XLEN'($signed(bus.IN_OP1) >>> shamt);
      4'd8: alu_result = bus.IN_OP1 | bus.IN_OP2;
      4'd9: alu_result = bus.IN_OP1 & bus.IN_OP2;
`ifdef EX_MUL_EN
      4'd10: is_mul = 1'b1;
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (bus.IN_BR_OP)
      3'd0: br_taken = bus.IN_OP1 == bus.IN_OP2;
      3'd1: br_taken = bus.IN_OP1 != bus.IN_OP2;
      3'd4: br_taken = $signed(bus.IN_OP1) <  $signed(bus.IN_OP2);
      3'd5: br_taken = $signed(bus.IN_OP1) >= $signed(bus.IN_OP2);
      3'd6: br_taken = bus.IN_OP1 <  bus.IN_OP2;
      3'd7: br_taken = bus.IN_OP1 >= bus.IN_OP2;
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum    = bus.IN_OP1 + bus.IN_IMM;
  assign jump_target = bus.IN_JALR ? {jalr_sum[XLEN-1:1], 1'b0} : bus.IN_PC + bus.IN_IMM;
  assign rd_nz       = |bus.IN_RD;

  assign in_ready = !busy && !bus.FLUSH && (!out_valid_reg || bus.OUT_READY);
  assign accept   = bus.IN_VALID && in_ready;

`ifdef EX_MUL_EN
  logic            busy_reg;
  logic [XLEN-1:0] mul_acc_reg;
  logic [XLEN-1:0] mul_mcand_reg;
  logic [XLEN-1:0] mul_mplier_reg;
  logic [SHW-1:0]  mul_cnt_reg;
  logic [XLEN-1:0] mul_sum;

  assign mul_sum = mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : '0);
  assign busy    = busy_reg;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      out_valid_reg   <= 1'b0;
      result_reg      <= '0;
      rd_reg          <= '0;
      we_reg          <= 1'b0;
      illegal_reg     <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
`ifdef EX_MUL_EN
      busy_reg        <= 1'b0;
      mul_acc_reg     <= '0;
      mul_mcand_reg   <= '0;
      mul_mplier_reg  <= '0;
      mul_cnt_reg     <= '0;
`endif
    end else if (bus.FLUSH) begin
      // a pulse already on REDIRECT this cycle is left alone; nothing new is issued
      out_valid_reg <= 1'b0;
      redirect_reg  <= 1'b0;
`ifdef EX_MUL_EN
      busy_reg      <= 1'b0;
`endif
    end else begin
      redirect_reg <= 1'b0;
      if (bus.OUT_READY)
        out_valid_reg <= 1'b0;
      if (accept) begin
        rd_reg      <= bus.IN_RD;
        illegal_reg <= 1'b0;
        if (bus.IN_BRANCH) begin
          out_valid_reg <= 1'b1;
          result_reg    <= '0;
          we_reg        <= 1'b0;
          redirect_reg  <= br_taken;
          if (br_taken)
            redirect_pc_reg <= jump_target;
        end else if (bus.IN_JAL || bus.IN_JALR) begin
          out_valid_reg   <= 1'b1;
          result_reg      <= bus.IN_PC + XLEN'(4);
          we_reg          <= rd_nz;
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= jump_target;
        end else if (is_mul) begin
          we_reg <= rd_nz;
`ifdef EX_MUL_EN
          busy_reg       <= 1'b1;
          mul_acc_reg    <= '0;
          mul_mcand_reg  <= bus.IN_OP1;
          mul_mplier_reg <= bus.IN_OP2;
          mul_cnt_reg    <= '0;
`endif
        end else begin
          out_valid_reg <= 1'b1;
          result_reg    <= alu_legal ? alu_result : '0;
          we_reg        <= alu_legal && rd_nz;
          illegal_reg   <= !alu_legal;
        end
      end
`ifdef EX_MUL_EN
      // fixed XLEN steps, no early exit, so latency never depends on operands
      if (busy_reg) begin
        mul_acc_reg    <= mul_sum;
        mul_mcand_reg  <= mul_mcand_reg << 1;
        mul_mplier_reg <= mul_mplier_reg >> 1;
        mul_cnt_reg    <= mul_cnt_reg + 1'b1;
        if (mul_cnt_reg == SHW'(XLEN-1)) begin
          busy_reg      <= 1'b0;
          out_valid_reg <= 1'b1;
          result_reg    <= mul_sum;
        end
      end
`endif
    end
  end

  assign bus.IN_READY    = in_ready;
  assign bus.OUT_VALID   = out_valid_reg;
  assign bus.OUT_RESULT  = result_reg;
  assign bus.OUT_RD      = rd_reg;
  assign bus.OUT_WE      = we_reg;
  assign bus.OUT_ILLEGAL = illegal_reg;
  assign bus.REDIRECT    = redirect_reg;
  assign bus.REDIRECT_PC = redirect_pc_reg;
  assign bus.BUSY        = busy;
endmodule
